// File: rtl/gpu_addr_unpack.sv
// Linear framebuffer address -> (x, y) decoder.
// Uses a one-quotient-bit-per-cycle restoring divider by the row width.
module gpu_addr_unpack #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [WIDTH_BITS+HEIGHT_BITS-1:0] in_addr,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [WIDTH_BITS-1:0]             out_x,
    output logic [HEIGHT_BITS-1:0]            out_y,
    output logic                              out_err,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam int K_BITS    = (HEIGHT_BITS > 1) ? $clog2(HEIGHT_BITS) : 1;
    localparam logic [ADDR_BITS:0]   PIXELS = (ADDR_BITS+1)'(WIDTH * HEIGHT);
    localparam logic [K_BITS-1:0]    K_TOP  = K_BITS'(HEIGHT_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   rem_q, rem_d;
    logic [HEIGHT_BITS-1:0] quot_q, quot_d;
    logic [K_BITS-1:0]      k_q, k_d;
    logic                   err_q, err_d;
    logic [WIDTH_BITS-1:0]  x_q, x_d;
    logic [HEIGHT_BITS-1:0] y_q, y_d;

    // Pre-shifted divisors WIDTH<<k, elaborated as constants at full width.
    logic [ADDR_BITS-1:0] div_tbl [HEIGHT_BITS];

    generate
        for (genvar gi = 0; gi < HEIGHT_BITS; gi++) begin : g_div
            assign div_tbl[gi] = ADDR_BITS'(WIDTH) << gi;
        end
    endgenerate

    logic                   trial_ge;
    logic [ADDR_BITS-1:0]   rem_step;
    logic [HEIGHT_BITS-1:0] quot_step;

    always_comb begin
        trial_ge  = (rem_q >= div_tbl[k_q]);
        rem_step  = rem_q;
        quot_step = quot_q;
        if (trial_ge) begin
            rem_step       = rem_q - div_tbl[k_q];
            quot_step[k_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        k_d     = k_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = in_addr;
                    quot_d  = '0;
                    k_d     = K_TOP;
                    err_d   = ({1'b0, in_addr} >= PIXELS);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d  = rem_step;
                quot_d = quot_step;
                k_d    = k_q - K_BITS'(1);
                if (k_q == '0) begin
                    k_d     = '0;
                    state_d = DONE;
                    // Out-of-range addresses report (0,0); the divider result is dropped.
                    x_d     = err_q ? '0 : rem_step[WIDTH_BITS-1:0];
                    y_d     = err_q ? '0 : quot_step;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            k_q     <= k_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_gpu_addr_unpack.sv
// Self-checking bench for gpu_addr_unpack: directed corner addresses, stalls,
// mid-operation reset and randomized traffic against an arithmetic model.
module tb_gpu_addr_unpack;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int WB = 10;
    localparam int HB = 9;
    localparam int AB = WB + HB;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [AB-1:0] in_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WB-1:0] out_x;
    logic [HB-1:0] out_y;
    logic          out_err;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    gpu_addr_unpack #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .WIDTH_BITS  (WB),
        .HEIGHT_BITS (HB)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // edge that releases the result, with the DUT idle again.
    task automatic do_xact(input int unsigned addr, input int stall);
        int          edges;
        int unsigned exp_x, exp_y, exp_err;
        logic [WB-1:0] hx;
        logic [HB-1:0] hy;
        logic          herr;
        exp_err = (addr >= W * H) ? 1 : 0;
        exp_x   = exp_err ? 0 : addr % W;
        exp_y   = exp_err ? 0 : addr / W;

        check("rdy_idle", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_addr   = AB'(addr);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rdy_calc", 32'(in_ready), 0);

        edges = 0;
        while (!out_valid && edges < 40) begin
            in_valid = 1'($urandom % 2);
            in_addr  = AB'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 32'(edges), HB);
        check("out_x", 32'(out_x), exp_x);
        check("out_y", 32'(out_y), exp_y);
        check("out_err", 32'(out_err), exp_err);
        check("rdy_done", 32'(in_ready), 0);
        hx = out_x; hy = out_y; herr = out_err;

        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_addr  = AB'($urandom);
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 1);
            check("stall_rdy", 32'(in_ready), 0);
            check("stall_x", 32'(out_x), 32'(hx));
            check("stall_y", 32'(out_y), 32'(hy));
            check("stall_err", 32'(out_err), 32'(herr));
        end

        in_valid  = 1'b1;
        in_addr   = AB'($urandom);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("rel_valid", 32'(out_valid), 0);
        check("rel_rdy", 32'(in_ready), 1);
        $display("xact addr=%0d x=%0d y=%0d err=%0d lat=%0d stall=%0d",
                 addr, hx, hy, herr, edges, stall);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_x", 32'(out_x), 0);
        check("rst_y", 32'(out_y), 0);
        check("rst_err", 32'(out_err), 0);
        n_rst = 1'b1;

        do_xact(0, 0);
        do_xact(639, 0);
        do_xact(640, 0);
        do_xact(307199, 1);
        do_xact(307200, 0);
        do_xact(524287, 2);
        do_xact(640, 5);
        do_xact(1283, 0);
        do_xact(307199, 0);

        // Reset while the divider is mid-way (k=4).
        in_valid = 1'b1;
        in_addr  = AB'(12345);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        n_rst = 1'b0;
        #1;
        check("mrst_x", 32'(out_x), 0);
        check("mrst_y", 32'(out_y), 0);
        check("mrst_err", 32'(out_err), 0);
        check("mrst_valid", 32'(out_valid), 0);
        check("mrst_rdy", 32'(in_ready), 1);
        @(posedge clk); #1;
        check("mrst_valid2", 32'(out_valid), 0);
        n_rst = 1'b1;
        do_xact(12345, 0);

        for (int t = 0; t < 40; t++) begin
            do_xact($urandom_range(0, W * H - 1), int'($urandom_range(0, 3)));
        end
        for (int t = 0; t < 4; t++) begin
            do_xact($urandom_range(W * H, (1 << AB) - 1), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gpu_addr_unpack.md
GPU_ADDR_UNPACK -- requirements
Module: gpu_addr_unpack

Interface
REQ-001 Parameter WIDTH, default 640, framebuffer pixels per row.
REQ-002 Parameter HEIGHT, default 480, framebuffer rows.
REQ-003 Parameter WIDTH_BITS, default 10, x coordinate width.
REQ-004 Parameter HEIGHT_BITS, default 9, y coordinate width.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 in_addr  input  WIDTH_BITS+HEIGHT_BITS  linear pixel address (y*WIDTH + x).
REQ-008 in_valid  input  1  in_addr is valid.
REQ-009 in_ready  output  1  block accepts a new address.
REQ-010 out_x  output  WIDTH_BITS  decoded column.
REQ-011 out_y  output  HEIGHT_BITS  decoded row.
REQ-012 out_err  output  1  in_addr >= WIDTH*HEIGHT.
REQ-013 out_valid  output  1  out_x/out_y/out_err are valid.
REQ-014 out_ready  input  1  consumer takes the result.

Function
REQ-015 The block SHALL perform the inverse of row-base packing: out_y = in_addr / WIDTH, out_x = in_addr mod WIDTH, using an iterative shift-subtract divider, with no combinational divider or multiplier on the datapath.
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-017 IDLE: in_ready=1 and out_valid=0; on an edge with in_valid=1, the block SHALL latch in_addr into remainder, clear quotient, set step index k=HEIGHT_BITS-1, register out_err = (in_addr >= WIDTH*HEIGHT), and go to CALC.
REQ-018 CALC: each cycle, if remainder >= (WIDTH<<k), the block SHALL subtract (WIDTH<<k) from remainder and set quotient bit k; k SHALL decrement; the step with k=0 SHALL transition to DONE.
REQ-019 Latency: out_valid SHALL assert exactly HEIGHT_BITS rising edges after the accepting edge (9 with defaults).
REQ-020 DONE: out_valid=1 and in_ready=0; out_x = remainder[WIDTH_BITS-1:0], out_y = quotient.
REQ-021 When out_err=1, out_x and out_y SHALL read 0 and the divider result SHALL be discarded.
REQ-022 Outputs SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-023 On an edge in DONE with out_ready=1, the block SHALL return to IDLE; a new address SHALL NOT be accepted on that same edge.
REQ-024 in_ready SHALL be 0 in CALC and DONE; in_valid and in_addr are ignored there.
REQ-025 Internal remainder and comparison SHALL be WIDTH_BITS+HEIGHT_BITS bits wide; (WIDTH<<k) SHALL never be truncated for k <= HEIGHT_BITS-1.
REQ-026 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-027 While n_rst=0: state=IDLE, in_ready=1, out_valid=0, out_x=0, out_y=0, out_err=0, remainder/quotient/k cleared.
REQ-028 Assertion of n_rst in CALC or DONE SHALL abandon the operation with no result emitted.
REQ-029 After n_rst deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-030 Defaults, in_addr=0 -> after 9 edges out_valid=1, out_x=0, out_y=0, out_err=0.
REQ-031 in_addr=639 -> (639,0); in_addr=640 -> (0,1); in_addr=307199 -> (639,479), err=0.
REQ-032 in_addr=307200 and in_addr=524287 -> out_err=1, out_x=0, out_y=0, same latency.
REQ-033 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second accept; release -> IDLE next edge, accept on following edge.
REQ-034 n_rst pulsed low in CALC (k=4) -> outputs zero immediately, no out_valid; next address decodes correctly.
REQ-035 Random in_addr in [0,307199] with random out_ready stalls -> every result equals (addr mod 640, addr/640), one result per accept, in order.
